// File: rtl/rot_addr_gen.sv
// DMA address generator for image rotation: reads each source row in bursts and
// emits the matching destination writes for a 0/90/180/270 degree rotation.
module rot_addr_gen #(
  parameter int ADDR_W    = 32,
  parameter int DIM_W     = 16,
  parameter int BURST_LEN = 16,
  parameter int PIX_SHIFT = 2
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET_N,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic              I_DIRECTION,
  input  logic [2:0]        I_DEGREES,
  input  logic [ADDR_W-1:0] I_SRC_BASE,
  input  logic [ADDR_W-1:0] I_DST_BASE,
  input  logic              I_DMA_READY,
  output logic              O_REQ,
  output logic [ADDR_W-1:0] O_ADDR,
  output logic              O_WRITE,
  output logic [2:0]        O_SIZE,
  output logic [4:0]        O_COUNT,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR
);

  localparam int PW = 2 * DIM_W;
  localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0] ONE_D = {{(DIM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // Byte address of pixel index idx; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [PW-1:0]     idx);
    logic [PW+PIX_SHIFT-1:0] w_off;
    w_off = (PW+PIX_SHIFT)'(idx) << PIX_SHIFT;
    return base + ADDR_W'(w_off);
  endfunction

  function automatic logic [4:0] chunk_len(input logic [DIM_W-1:0] w,
                                           input logic [DIM_W-1:0] x);
    logic [DIM_W-1:0] w_rem;
    w_rem = w - x;
    if (w_rem >= DIM_W'(BURST_LEN)) return 5'(BURST_LEN);
    else                            return w_rem[4:0];
  endfunction

  function automatic logic [PW-1:0] src_idx(input logic [DIM_W-1:0] x,
                                            input logic [DIM_W-1:0] y,
                                            input logic [DIM_W-1:0] w);
    return PW'(y) * PW'(w) + PW'(x);
  endfunction

  // Destination pixel index of source pixel (x,y) after rotation rot.
  function automatic logic [PW-1:0] dst_idx(input logic [1:0]       rot,
                                            input logic [DIM_W-1:0] x,
                                            input logic [DIM_W-1:0] y,
                                            input logic [DIM_W-1:0] w,
                                            input logic [DIM_W-1:0] h);
    logic [PW-1:0] w_px, w_py, w_pw, w_ph, w_res;
    w_px = PW'(x);
    w_py = PW'(y);
    w_pw = PW'(w);
    w_ph = PW'(h);
    case (rot)
      2'd0:    w_res = w_py * w_pw + w_px;
      2'd1:    w_res = w_px * w_ph + (w_ph - w_py - ONE_P);
      2'd2:    w_res = (w_ph - w_py - ONE_P) * w_pw + (w_pw - w_px - ONE_P);
      2'd3:    w_res = (w_pw - w_px - ONE_P) * w_ph + w_py;
      default: w_res = w_py * w_pw + w_px;
    endcase
    return w_res;
  endfunction

  state_t            r_state, w_state_nx;
  logic [DIM_W-1:0]  r_w, r_h, r_x, r_y;
  logic [DIM_W-1:0]  w_w_nx, w_h_nx, w_x_nx, w_y_nx;
  logic [1:0]        r_rot, w_rot_nx;
  logic [ADDR_W-1:0] r_src, r_dst, w_src_nx, w_dst_nx;
  logic [4:0]        r_n, r_k, w_n_nx, w_k_nx;
  logic              r_req, r_write, r_busy, r_done, r_err;
  logic              w_req_nx, w_write_nx, w_busy_nx, w_done_nx, w_err_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [4:0]        r_count, w_count_nx;

  logic              w_xfer, w_start_ok, w_row_end, w_last_chunk, w_chunk_end;
  logic [1:0]        w_rot_in;
  logic [DIM_W-1:0]  w_end_x, w_next_x, w_next_y, w_wr_px_nx;
  logic [4:0]        w_next_n, w_first_n;

  // Next-state, traversal position and registered request outputs.
  always_comb begin
    w_state_nx = r_state;
    w_w_nx     = r_w;
    w_h_nx     = r_h;
    w_rot_nx   = r_rot;
    w_src_nx   = r_src;
    w_dst_nx   = r_dst;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_n_nx     = r_n;
    w_k_nx     = r_k;
    w_req_nx   = r_req;
    w_addr_nx  = r_addr;
    w_write_nx = r_write;
    w_count_nx = r_count;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;

    w_xfer       = r_req & I_DMA_READY;
    w_start_ok   = (I_WIDTH != '0) && (I_HEIGHT != '0) && !I_DEGREES[2];
    w_rot_in     = I_DIRECTION ? (2'd0 - I_DEGREES[1:0]) : I_DEGREES[1:0];
    w_first_n    = chunk_len(I_WIDTH, '0);
    w_end_x      = r_x + DIM_W'(r_n);
    w_row_end    = (w_end_x >= r_w);
    w_next_x     = w_row_end ? '0 : w_end_x;
    w_next_y     = w_row_end ? (r_y + ONE_D) : r_y;
    w_next_n     = chunk_len(r_w, w_next_x);
    w_last_chunk = w_row_end && (r_y == (r_h - ONE_D));
    w_chunk_end  = (r_rot == 2'd0) || (r_k == (r_n - 5'd1));
    w_wr_px_nx   = r_x + DIM_W'(r_k) + ONE_D;

    case (r_state)
      IDLE: begin
        w_req_nx = 1'b0;
        if (I_START && w_start_ok) begin
          w_state_nx = RD;
          w_w_nx     = I_WIDTH;
          w_h_nx     = I_HEIGHT;
          w_rot_nx   = w_rot_in;
          w_src_nx   = I_SRC_BASE;
          w_dst_nx   = I_DST_BASE;
          w_x_nx     = '0;
          w_y_nx     = '0;
          w_n_nx     = w_first_n;
          w_k_nx     = 5'd0;
          w_req_nx   = 1'b1;
          w_addr_nx  = I_SRC_BASE;
          w_write_nx = 1'b0;
          w_count_nx = w_first_n;
        end else if (I_START) begin
          w_err_nx = 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      RD: begin
        if (I_ABORT) begin
          w_state_nx = IDLE;
          w_req_nx   = 1'b0;
          w_write_nx = 1'b0;
        end else if (w_xfer) begin
          w_state_nx = WR;
          w_k_nx     = 5'd0;
          w_write_nx = 1'b1;
          w_addr_nx  = pix_addr(r_dst, dst_idx(r_rot, r_x, r_y, r_w, r_h));
          w_count_nx = (r_rot == 2'd0) ? r_n : 5'd1;
        end else begin
          w_req_nx = 1'b1;
        end
      end
      WR: begin
        if (I_ABORT) begin
          w_state_nx = IDLE;
          w_req_nx   = 1'b0;
          w_write_nx = 1'b0;
        end else if (w_xfer && w_chunk_end && w_last_chunk) begin
          w_state_nx = IDLE;
          w_req_nx   = 1'b0;
          w_write_nx = 1'b0;
          w_done_nx  = 1'b1;
        end else if (w_xfer && w_chunk_end) begin
          w_state_nx = RD;
          w_x_nx     = w_next_x;
          w_y_nx     = w_next_y;
          w_n_nx     = w_next_n;
          w_write_nx = 1'b0;
          w_addr_nx  = pix_addr(r_src, src_idx(w_next_x, w_next_y, r_w));
          w_count_nx = w_next_n;
        end else if (w_xfer) begin
          // Rotated chunks go out one pixel at a time, left to right.
          w_k_nx     = r_k + 5'd1;
          w_addr_nx  = pix_addr(r_dst, dst_idx(r_rot, w_wr_px_nx, r_y, r_w, r_h));
          w_count_nx = 5'd1;
        end else begin
          w_req_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_req_nx   = 1'b0;
      end
    endcase

    w_busy_nx = (w_state_nx != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_rot   <= 2'd0;
      r_src   <= '0;
      r_dst   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_n     <= 5'd0;
      r_k     <= 5'd0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_count <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_w     <= w_w_nx;
      r_h     <= w_h_nx;
      r_rot   <= w_rot_nx;
      r_src   <= w_src_nx;
      r_dst   <= w_dst_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_n     <= w_n_nx;
      r_k     <= w_k_nx;
      r_req   <= w_req_nx;
      r_addr  <= w_addr_nx;
      r_write <= w_write_nx;
      r_count <= w_count_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  assign O_REQ   = r_req;
  assign O_ADDR  = r_addr;
  assign O_WRITE = r_write;
  assign O_SIZE  = 3'(PIX_SHIFT);
  assign O_COUNT = r_count;
  assign O_BUSY  = r_busy;
  assign O_DONE  = r_done;
  assign O_ERR   = r_err;

endmodule

// File: tb/tb_rot_addr_gen.sv
// Scoreboard bench for rot_addr_gen: table of rotation jobs plus hand-written
// error, stall/abort and mid-job reset sequences.
module tb_rot_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort_i, dir, ready;
  logic [15:0] width, height;
  logic [2:0]  deg;
  logic [31:0] src, dst;
  logic        o_req, o_write, o_busy, o_done, o_err;
  logic [31:0] o_addr;
  logic [2:0]  o_size;
  logic [4:0]  o_count;

  rot_addr_gen dut (
    .I_HCLK(clk), .I_HRESET_N(rst_n), .I_START(start), .I_ABORT(abort_i),
    .I_WIDTH(width), .I_HEIGHT(height), .I_DIRECTION(dir), .I_DEGREES(deg),
    .I_SRC_BASE(src), .I_DST_BASE(dst), .I_DMA_READY(ready),
    .O_REQ(o_req), .O_ADDR(o_addr), .O_WRITE(o_write), .O_SIZE(o_size),
    .O_COUNT(o_count), .O_BUSY(o_busy), .O_DONE(o_done), .O_ERR(o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [4:0]  cnt;
  } req_t;

  typedef struct {
    int          w, h, dg, dr, rmode, nreq;
    logic [31:0] first_wr, last_wr;
  } vec_t;

  req_t        q[$];
  vec_t        tbl[8];
  int          n_checks = 0, n_pass = 0;
  int          n_done = 0, n_err = 0, n_xfer = 0;
  int          rdy_mode = 0;
  logic        seen_wr = 1'b0, stall_prev = 1'b0;
  logic [31:0] first_wr = '0, last_wr = '0;
  req_t        held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference request stream for one job.
  task automatic model(input int w, input int h, input int dg, input int dr);
    int r, n, idx, px;
    r = dr ? ((4 - dg) % 4) : dg;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x += n) begin
        n = (w - x > 16) ? 16 : (w - x);
        q.push_back('{1'b0, 32'h1000 + 32'((y * w + x) << 2), 5'(n)});
        if (r == 0) q.push_back('{1'b1, 32'h2000 + 32'((y * w + x) << 2), 5'(n)});
        else begin
          for (int k = 0; k < n; k++) begin
            px = x + k;
            case (r)
              1: idx = px * h + (h - 1 - y);
              2: idx = (h - 1 - y) * w + (w - 1 - px);
              default: idx = (w - 1 - px) * h + y;
            endcase
            q.push_back('{1'b1, 32'h2000 + 32'(idx << 2), 5'd1});
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) ready = 1'b1;
      else if (rdy_mode == 1) ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake stability, scoreboard compare, pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_prev && o_req) chk("hold", {o_write, o_addr, o_count}, held);
      stall_prev = o_req && !ready;
      held = '{o_write, o_addr, o_count};
      if (o_req && ready) begin
        n_xfer++;
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: got %0h expected none", {o_write, o_addr, o_count});
        end else chk("req", {o_write, o_addr, o_count}, q.pop_front());
        if (o_write) begin
          if (!seen_wr) first_wr = o_addr;
          seen_wr = 1'b1;
          last_wr = o_addr;
        end
      end
      if (o_done) begin
        n_done++;
        chk("done_req_low", o_req, 0);
      end
      if (o_err) n_err++;
    end
  end

  task automatic cfg(input int w, input int h, input int dg, input int dr);
    width = 16'(w); height = 16'(h); deg = 3'(dg); dir = 1'(dr);
    src = 32'h1000; dst = 32'h2000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_job(input int i);
    int cyc;
    q.delete();
    n_done = 0; n_xfer = 0; seen_wr = 1'b0;
    rdy_mode = tbl[i].rmode;
    cfg(tbl[i].w, tbl[i].h, tbl[i].dg, tbl[i].dr);
    model(tbl[i].w, tbl[i].h, tbl[i].dg, tbl[i].dr);
    pulse_start();
    cfg(7, 3, 2, 1 - tbl[i].dr);
    src = 32'h5000; dst = 32'h6000;
    pulse_start();
    cyc = 0;
    while (o_busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout", 64'(cyc < 5000), 64'd1);
    repeat (3) @(posedge clk);
    chk("nreq", n_xfer, tbl[i].nreq);
    chk("done_cnt", n_done, 1);
    chk("first_wr", first_wr, tbl[i].first_wr);
    chk("last_wr", last_wr, tbl[i].last_wr);
    chk("queue_empty", q.size(), 0);
    rdy_mode = 0;
  endtask

  initial begin
    tbl[0] = '{8, 8, 0, 0, 0, 16, 32'h2000, 32'h20E0};
    tbl[1] = '{4, 2, 1, 0, 0, 10, 32'h2004, 32'h2018};
    tbl[2] = '{4, 2, 1, 1, 1, 10, 32'h2018, 32'h2004};
    tbl[3] = '{4, 2, 3, 0, 0, 10, 32'h2018, 32'h2004};
    tbl[4] = '{123, 5, 0, 0, 1, 80, 32'h2000, 32'h2970};
    tbl[5] = '{3, 5, 2, 0, 0, 20, 32'h2038, 32'h2000};
    tbl[6] = '{5, 3, 2, 1, 1, 18, 32'h2038, 32'h2000};
    tbl[7] = '{20, 1, 0, 1, 0, 4, 32'h2000, 32'h2040};

    rst_n = 1'b0; start = 1'b0; abort_i = 1'b0; ready = 1'b1;
    cfg(8, 8, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", o_req, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_count", o_count, 0);
    chk("size", o_size, 2);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_job(i);

    // Illegal starts: degrees=5, then width=0.
    n_err = 0;
    cfg(8, 8, 5, 0);
    pulse_start();
    @(negedge clk);
    chk("err_deg_pulse", o_err, 1);
    chk("err_deg_busy", o_busy, 0);
    @(negedge clk);
    chk("err_deg_one", o_err, 0);
    cfg(0, 8, 0, 0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("err_w0_busy", o_busy, 0);
    @(posedge clk);
    chk("err_cnt", n_err, 2);
    chk("err_no_req", n_xfer, 4);

    // Stall 5 cycles mid-job, then abort.
    q.delete(); n_done = 0; rdy_mode = 2; ready = 1'b1;
    cfg(8, 8, 0, 0);
    model(8, 8, 0, 0);
    pulse_start();
    repeat (2) @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    held = '{o_write, o_addr, o_count};
    chk("stall_req", o_req, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_hold", {o_write, o_addr, o_count}, {held.wr, held.addr, held.cnt});
    end
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", o_busy, 0);
    chk("abort_req", o_req, 0);
    repeat (5) @(posedge clk);
    chk("abort_no_done", n_done, 0);
    q.delete(); rdy_mode = 0;

    // Reset in the middle of a rotated job.
    n_done = 0;
    cfg(4, 2, 1, 0);
    model(4, 2, 1, 0);
    pulse_start();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_outs", {o_req, o_addr, o_write, o_count, o_busy, o_done, o_err}, 0);
    repeat (5) @(negedge clk);
    chk("mrst_no_resume", {o_busy, o_req}, 0);
    @(posedge clk);
    chk("mrst_no_done", n_done, 0);
    q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
